multicycle_instruction: RTL and testbench
=========================================

# multicycle_instruction

Parametrised multi-cycle successor to the single-cycle instruction datapath. Accepts one RISC-V instruction at a time over a valid/ready handshake and sequences it through execute, an optional memory access, and writeback. Main memory sits behind a request/acknowledge port with variable latency. The block sits between the fetch/PC logic (which supplies `instr` and `pc_next`) and the data memory, and owns the architectural register file.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 or 64.
- `REGS`, 32: architectural register count; 32, or 16 for the E variant.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `instr_valid`  in  1  `instr`/`pc_next` valid.
- `instr_ready`  out  1  block idle and able to accept.
- `instr`  in  32  instruction word.
- `pc_next`  in  XLEN  link value for JAL.
- `mem_req`  out  1  memory request; held until ack.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  XLEN  byte address.
- `mem_wdata`  out  XLEN  store data (rs2).
- `mem_size`  out  3  funct3 of the load/store.
- `mem_ack`  in  1  request completed; `mem_rdata` valid this cycle.
- `mem_rdata`  in  XLEN  right-justified load data.
- `retire_valid`  out  1  one-cycle pulse per completed instruction.
- `retire_we`  out  1  a register was written.
- `retire_rd`  out  5  destination index.
- `retire_data`  out  XLEN  written value.
- `error`  out  1  misalignment pulse, coincident with `retire_valid`.

## Operation
- FSM states: IDLE, EXEC, MEM, WB.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and `pc_next`, then go to EXEC.
- EXEC:
  - Decode the instruction, read rs1/rs2, compute the ALU result into a register.
  - LOAD/STORE go to MEM.
  - All other instructions go to WB.
- Supported instructions:
  - OP-IMM and OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is the low log2(XLEN) bits.
  - LUI: writes `{imm[31:12],12'h0}` sign-extended to XLEN.
  - JAL: writes `pc_next`. No redirect; the PC is owned externally.
  - LOAD, STORE.
- Any other opcode retires with `retire_we`=0.
- Immediates are sign-extended to XLEN. Address = rs1 + imm, wrapping modulo 2^XLEN.
- MEM:
  - Drive `mem_req`=1 with addr/we/wdata/size stable until the cycle `mem_ack`=1, then go to WB.
  - `mem_ack` outside MEM is ignored.
- Load extension by funct3:
  - 000: sign-extend byte. 001: sign-extend half. 100: zero-extend byte. 101: zero-extend half.
  - 010: word; sign-extended when XLEN=64.
  - 110 (LWU) and 011 (LD): XLEN=64 only.
  - Otherwise (including 110/011 at XLEN=32): treated as illegal, no write.
- WB:
  - Pulse `retire_valid`, write the register file at the clock edge, return to IDLE.
  - Stores retire with `retire_we`=0.
- Writes to x0 are discarded, with `retire_we`=0. Reads of x0 return 0.
- With REGS=16, accesses with index bit 4 set are handled as x0.

## Timing
- Handshake accepted at edge T. The instruction is in EXEC during cycle T+1.
- ALU/LUI/JAL: `retire_valid` in cycle T+2; `instr_ready`=1 in cycle T+3. Issue interval is 3 cycles.
- LOAD/STORE: `mem_req` rises in cycle T+2. If ack arrives N cycles later (N≥0 extra cycles), retire is in cycle T+3+N.
- The register write is visible to the next instruction's EXEC.
- Reset values: state IDLE, every output 0 except `instr_ready`=1, all registers 0.
- Reset asserted mid-operation (including MEM) drops `mem_req` asynchronously. The instruction is abandoned with no retire.

## Configuration
- `MULTICYCLE_MISALIGN_TRAP_EN` defined:
  - A load/store whose address is not aligned to its access size skips MEM. No `mem_req` is issued.
  - It goes EXEC→WB with `retire_we`=0 and `error`=1.
- Macro undefined: the address is issued unchanged and `error` is tied to 0.

## Structure
- Shared package `multicycle_pkg`:
  - Opcode constants (OP_IMM, OP, LUI, JAL, LOAD, STORE).
  - funct3 width/size constants.
  - ALU operation enum.
  - FSM state enum.
- One sub-module, `multicycle_decoder`: combinational decode of the latched instruction into ALU op, immediate, source select, memory control and write-enable.
- Register file and ALU are internal to the top.

## Test plan
- Reset, ADDI x1,x0,5 accepted at T → `retire_valid` at T+2, rd=1, data=5, `instr_ready` at T+3.
- x1=5, x2=7; SUB x3,x1,x2 → `retire_data`=0xFFFFFFFE. SRA x4,x3,1 → 0xFFFFFFFF.
- LB x5,0(x1) with `mem_ack` delayed 3 cycles, `mem_rdata`=0x80:
  - `mem_req` held 4 cycles, addr 5, size 000.
  - Retire data 0xFFFFFF80. LBU gives 0x80.
- x1=8; SW x2,4(x1) → `mem_req`=1, `mem_we`=1, addr 12, wdata 7, size 010; retire with `retire_we`=0.
- Macro defined, x1=3; LW x6,0(x1) → no `mem_req`, `error`=1 with `retire_valid`, x6 unchanged.
- `rst_n` low during MEM → `mem_req` 0 immediately, no retire, `instr_ready`=1 after release; x1 reads 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared constants and types for the multi-cycle instruction datapath:
// opcodes, funct3 access sizes, ALU operations and sequencer states.
package multicycle_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam int FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_LD  = 3'b011;
    localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_LWU = 3'b110;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_EXEC, ST_MEM, ST_WB
    } state_e;

    // funct3[1:0] encodes log2 of the access size; the mask covers the
    // address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] access_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_decoder.sv
// Combinational decode of the latched instruction word into ALU operation,
// sign-extended immediate, operand select, memory control and write enable.
module multicycle_decoder
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output alu_op_e          alu_op,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic             is_jal,
    output logic             is_load,
    output logic             is_store,
    output logic             reg_we,
    output logic [4:0]       rs1_idx,
    output logic [4:0]       rs2_idx,
    output logic [4:0]       rd_idx
);

    logic [6:0]          opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                alt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];

    // alt selects SUB only for register-register ops; for shifts it selects SRA either way.
    function automatic alu_op_e f3_op(input logic [FUNCT3_W-1:0] f3, input logic alt_bit,
                                      input logic is_reg_op);
        case (f3)
            3'b000:  return (is_reg_op && alt_bit) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_bit ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_op   = ALU_ADD;
        imm      = '0;
        use_imm  = 1'b0;
        is_jal   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        reg_we   = 1'b0;
        rs1_idx  = instr[19:15];
        rs2_idx  = instr[24:20];
        rd_idx   = instr[11:7];
        case (opcode)
            OPC_OP_IMM: begin
                alu_op  = f3_op(funct3, alt, 1'b0);
                imm     = XLEN'($signed(instr[31:20]));
                use_imm = 1'b1;
                reg_we  = 1'b1;
            end
            OPC_OP: begin
                alu_op = f3_op(funct3, alt, 1'b1);
                reg_we = 1'b1;
            end
            OPC_LUI: begin
                rs1_idx = 5'd0;
                imm     = XLEN'($signed({instr[31:12], 12'h000}));
                use_imm = 1'b1;
                reg_we  = 1'b1;
            end
            OPC_JAL: begin
                is_jal = 1'b1;
                reg_we = 1'b1;
            end
            OPC_LOAD: begin
                imm     = XLEN'($signed(instr[31:20]));
                use_imm = 1'b1;
                is_load = 1'b1;
                reg_we  = 1'b1;
            end
            OPC_STORE: begin
                imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
                use_imm  = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_instruction.sv
// Multi-cycle RISC-V instruction sequencer: IDLE -> EXEC -> [MEM] -> WB.
// Define MULTICYCLE_MISALIGN_TRAP_EN to retire misaligned loads/stores with error instead of issuing them.
module multicycle_instruction
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc_next,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [2:0]          mem_size,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                retire_valid,
    output logic                retire_we,
    output logic [4:0]          retire_rd,
    output logic [XLEN-1:0]     retire_data,
    output logic                error
);

    localparam int SHW = $clog2(XLEN);
    localparam int RW  = $clog2(REGS);

    state_e              state_q, state_d;
    logic [31:0]         instr_q;
    logic [XLEN-1:0]     pc_q, result_q, wdata_q;
    logic                err_q;
    logic [XLEN-1:0]     regs_q [REGS];

    alu_op_e             alu_op;
    logic [XLEN-1:0]     imm, rs1_val, rs2_val, op_b, alu_out, load_value;
    logic                use_imm, is_jal, is_load, is_store, reg_we;
    logic                load_legal, trap, wb_we;
    logic [4:0]          rs1_idx, rs2_idx, rd_idx, rs1_a, rs2_a, rd_a;
    logic [FUNCT3_W-1:0] funct3;
    logic [SHW-1:0]      shamt;

    multicycle_decoder #(.XLEN(XLEN)) u_decoder (
        .instr    (instr_q),
        .alu_op   (alu_op),
        .imm      (imm),
        .use_imm  (use_imm),
        .is_jal   (is_jal),
        .is_load  (is_load),
        .is_store (is_store),
        .reg_we   (reg_we),
        .rs1_idx  (rs1_idx),
        .rs2_idx  (rs2_idx),
        .rd_idx   (rd_idx)
    );

    // The E variant has no x16..x31; those indices alias x0.
    function automatic logic [4:0] arch_idx(input logic [4:0] idx);
        return (REGS == 16 && idx[4]) ? 5'd0 : idx;
    endfunction

    assign rs1_a   = arch_idx(rs1_idx);
    assign rs2_a   = arch_idx(rs2_idx);
    assign rd_a    = arch_idx(rd_idx);
    assign rs1_val = (rs1_a == 5'd0) ? '0 : regs_q[rs1_a[RW-1:0]];
    assign rs2_val = (rs2_a == 5'd0) ? '0 : regs_q[rs2_a[RW-1:0]];
    assign op_b    = use_imm ? imm : rs2_val;
    assign shamt   = op_b[SHW-1:0];
    assign funct3  = instr_q[14:12];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = rs1_val + op_b;
            ALU_SUB:  alu_out = rs1_val - op_b;
            ALU_SLL:  alu_out = rs1_val << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (rs1_val < op_b)};
            ALU_XOR:  alu_out = rs1_val ^ op_b;
            ALU_SRL:  alu_out = rs1_val >> shamt;
            ALU_SRA:  alu_out = $signed(rs1_val) >>> shamt;
            ALU_OR:   alu_out = rs1_val | op_b;
            ALU_AND:  alu_out = rs1_val & op_b;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        load_legal = 1'b1;
        load_value = '0;
        case (funct3)
            F3_LB:   load_value = XLEN'($signed(mem_rdata[7:0]));
            F3_LH:   load_value = XLEN'($signed(mem_rdata[15:0]));
            F3_LBU:  load_value = XLEN'(mem_rdata[7:0]);
            F3_LHU:  load_value = XLEN'(mem_rdata[15:0]);
            F3_LW:   load_value = XLEN'($signed(mem_rdata[31:0]));
            F3_LWU:  begin load_value = XLEN'(mem_rdata[31:0]); load_legal = (XLEN == 64); end
            F3_LD:   begin load_value = mem_rdata;               load_legal = (XLEN == 64); end
            default: load_legal = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_MISALIGN_TRAP_EN
    assign trap  = (is_load || is_store) && |(alu_out[2:0] & access_mask(funct3[1:0]));
    assign error = retire_valid && err_q;
`else
    assign trap  = 1'b0;
    assign error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ((is_load || is_store) && !trap) ? ST_MEM : ST_WB;
            ST_MEM:  if (mem_ack) state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (instr_valid) begin
                    instr_q <= instr;
                    pc_q    <= pc_next;
                end
                ST_EXEC: begin
                    result_q <= is_jal ? pc_q : alu_out;
                    wdata_q  <= rs2_val;
                    err_q    <= trap;
                end
                ST_MEM: if (mem_ack) result_q <= load_value;
                default: ;
            endcase
        end
    end

    assign wb_we = (state_q == ST_WB) && reg_we && (rd_a != 5'd0) && !err_q
                   && (!is_load || load_legal);

    // NOTE: the register file is reset because a clean all-zero architectural
    // state is required after reset; this rules out a RAM macro here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[rd_a[RW-1:0]] <= result_q;
        end
    end

    assign instr_ready  = (state_q == ST_IDLE);
    assign mem_req      = (state_q == ST_MEM);
    assign mem_we       = mem_req && is_store;
    assign mem_addr     = mem_req ? result_q : '0;
    assign mem_wdata    = mem_req ? wdata_q : '0;
    assign mem_size     = mem_req ? funct3 : '0;
    assign retire_valid = (state_q == ST_WB);
    assign retire_we    = wb_we;
    assign retire_rd    = wb_we ? rd_a : 5'd0;
    assign retire_data  = retire_valid ? result_q : '0;

endmodule

// File: tb/tb_multicycle_instruction.sv
// Directed bench for multicycle_instruction (XLEN=32, REGS=32); expectations
// follow MULTICYCLE_MISALIGN_TRAP_EN when it is defined for the build.
module tb_multicycle_instruction;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc_next = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        retire_valid, retire_we;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_instruction #(.XLEN(32), .REGS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .pc_next      (pc_next),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .retire_valid (retire_valid),
        .retire_we    (retire_we),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the block idle; the handshake lands on the next posedge (T).
    task automatic issue(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] w, input logic exp_we,
                           input logic [4:0] exp_rd, input logic [31:0] exp_data);
        issue(w);
        check({tag, "/exec_ready"}, instr_ready, 0);
        check({tag, "/exec_retire"}, retire_valid, 0);
        @(negedge clk);
        check({tag, "/retire_valid"}, retire_valid, 1);
        check({tag, "/retire_we"}, retire_we, exp_we);
        check({tag, "/retire_rd"}, retire_rd, exp_rd);
        if (exp_we) check({tag, "/retire_data"}, retire_data, exp_data);
        check({tag, "/error"}, error, 0);
        check({tag, "/no_req"}, mem_req, 0);
        @(negedge clk);
        check({tag, "/ready"}, instr_ready, 1);
        check({tag, "/pulse"}, retire_valid, 0);
    endtask

    task automatic run_mem(input string tag, input logic [31:0] w, input int n,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic exp_mwe, input logic [31:0] exp_wdata,
                           input logic [2:0] exp_size, input logic exp_we,
                           input logic [4:0] exp_rd, input logic [31:0] exp_data);
        int req_cycles = 0;
        issue(w);
        check({tag, "/exec_req"}, mem_req, 0);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            check({tag, "/retire_early"}, retire_valid, 0);
            check({tag, "/addr"}, mem_addr, exp_addr);
            if (i == 0) begin
                check({tag, "/mem_we"}, mem_we, exp_mwe);
                check({tag, "/size"}, mem_size, exp_size);
                if (exp_mwe) check({tag, "/wdata"}, mem_wdata, exp_wdata);
            end
            if (i == n) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check({tag, "/req_cycles"}, req_cycles, n + 1);
        check({tag, "/req_drop"}, mem_req, 0);
        check({tag, "/retire_valid"}, retire_valid, 1);
        check({tag, "/retire_we"}, retire_we, exp_we);
        check({tag, "/retire_rd"}, retire_rd, exp_rd);
        if (exp_we) check({tag, "/retire_data"}, retire_data, exp_data);
        @(negedge clk);
        check({tag, "/ready"}, instr_ready, 1);
    endtask

    initial begin
        #12;
        check("reset/instr_ready", instr_ready, 1);
        check("reset/mem_req", mem_req, 0);
        check("reset/retire_valid", retire_valid, 0);
        check("reset/retire_data", retire_data, 0);
        check("reset/error", error, 0);
        check("reset/mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_alu("addi_x1", 32'h0050_0093, 1, 5'd1, 32'd5);
        run_alu("addi_x2", 32'h0070_0113, 1, 5'd2, 32'd7);
        run_alu("sub_x3",  32'h4020_81B3, 1, 5'd3, 32'hFFFF_FFFE);
        run_alu("srai_x4", 32'h4011_D213, 1, 5'd4, 32'hFFFF_FFFF);

        run_mem("lb",  32'h0000_8283, 3, 32'h80, 32'd5, 0, 32'd0, 3'b000, 1, 5'd5, 32'hFFFF_FF80);
        run_mem("lbu", 32'h0000_C283, 0, 32'h80, 32'd5, 0, 32'd0, 3'b100, 1, 5'd5, 32'h0000_0080);

        run_alu("addi_x1_8", 32'h0080_0093, 1, 5'd1, 32'd8);
        run_mem("sw", 32'h0020_A223, 1, 32'd0, 32'd12, 1, 32'd7, 3'b010, 0, 5'd0, 32'd0);
        run_alu("or_x8",    32'h0020_E433, 1, 5'd8, 32'h0000_000F);
        run_alu("lui_x6",   32'h1234_5337, 1, 5'd6, 32'h1234_5000);
        pc_next = 32'h0000_0100;
        run_alu("jal_x7",   32'h0000_03EF, 1, 5'd7, 32'h0000_0100);
        pc_next = '0;
        run_alu("addi_x0",  32'h0090_0013, 0, 5'd0, 32'd0);
        run_alu("illegal",  32'h0000_058B, 0, 5'd0, 32'd0);
        run_alu("addi_x1_3", 32'h0030_0093, 1, 5'd1, 32'd3);

`ifdef MULTICYCLE_MISALIGN_TRAP_EN
        issue(32'h0000_A303);
        check("lw_mis/exec_req", mem_req, 0);
        @(negedge clk);
        check("lw_mis/req", mem_req, 0);
        check("lw_mis/retire_valid", retire_valid, 1);
        check("lw_mis/error", error, 1);
        check("lw_mis/retire_we", retire_we, 0);
        @(negedge clk);
        check("lw_mis/ready", instr_ready, 1);
        check("lw_mis/error_pulse", error, 0);
        run_alu("read_x6", 32'h0003_0493, 1, 5'd9, 32'h1234_5000);
`else
        run_mem("lw_mis", 32'h0000_A303, 0, 32'hCAFE_F00D, 32'd3, 0, 32'd0, 3'b010, 1, 5'd6, 32'hCAFE_F00D);
        run_alu("read_x6", 32'h0003_0493, 1, 5'd9, 32'hCAFE_F00D);
`endif

        // Reset while the load is waiting for its acknowledge.
        issue(32'h0000_8283);
        @(negedge clk);
        check("rst_mem/req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem/req_async", mem_req, 0);
        check("rst_mem/ready_async", instr_ready, 1);
        check("rst_mem/retire_async", retire_valid, 0);
        @(negedge clk);
        check("rst_mem/retire_held", retire_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem/ready", instr_ready, 1);
        check("rst_mem/retire_after", retire_valid, 0);
        run_alu("read_x1", 32'h0000_8393, 1, 5'd7, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
